// File: rtl/tcu_reg_bridge.sv
// Request/response bridge onto the TCU register mux (IF2 port).
// Define TCU_REG_BRIDGE_TIMEOUT_EN to abort accesses stalled for TIMEOUT_CYCLES.
module tcu_reg_bridge #(
    parameter int TCU_REG_DATA_SIZE = 64,
    parameter int TCU_REG_ADDR_SIZE = 32,
    parameter int TCU_REG_BSEL_SIZE = 8,
    parameter int TIMEOUT_CYCLES    = 255
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic                         req_we_i,
    input  logic [1:0]                   req_src_i,
    input  logic [TCU_REG_BSEL_SIZE-1:0] req_bsel_i,
    input  logic [TCU_REG_ADDR_SIZE-1:0] req_addr_i,
    input  logic [TCU_REG_DATA_SIZE-1:0] req_wdata_i,
    output logic                         resp_valid_o,
    input  logic                         resp_ready_i,
    output logic [TCU_REG_DATA_SIZE-1:0] resp_rdata_o,
    output logic                         resp_err_o,
    output logic [2:0]                   reg_en_o,
    output logic [TCU_REG_DATA_SIZE-1:0] reg_wben_o,
    output logic [TCU_REG_ADDR_SIZE-1:0] reg_addr_o,
    output logic [TCU_REG_DATA_SIZE-1:0] reg_wdata_o,
    input  logic [TCU_REG_DATA_SIZE-1:0] reg_rdata_i,
    input  logic                         reg_stall_i
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, RESP} state_t;

    state_t                         state;
    state_t                         state_nxt;
    logic                           we_q;
    logic [1:0]                     src_q;
    logic [TCU_REG_BSEL_SIZE-1:0]   bsel_q;
    logic [TCU_REG_ADDR_SIZE-1:0]   addr_q;
    logic [TCU_REG_DATA_SIZE-1:0]   wdata_q;
    logic [TCU_REG_DATA_SIZE-1:0]   rdata_q;
    logic                           accept;
    logic                           done;
    logic                           timeout;

`ifdef TCU_REG_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                           $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    // Fires on the stalled cycle that brings the count to TIMEOUT_CYCLES.
    assign timeout = (state == ISSUE) && reg_stall_i &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state != ISSUE)
                cnt_q <= '0;
            else if (reg_stall_i)
                cnt_q <= cnt_q + 1'b1;
            if (timeout)
                err_q <= 1'b1;
            else if (done)
                err_q <= 1'b0;
        end
    end

    assign resp_err_o = err_q;
`else
    assign timeout    = 1'b0;
    assign resp_err_o = 1'b0;
`endif

    assign req_ready_o = (state == IDLE) && reset_n_i;
    assign accept      = req_valid_i && req_ready_o;
    assign done        = (state == ISSUE) && !reg_stall_i;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   if (accept) state_nxt = ISSUE;
            ISSUE: begin
                if (done)
                    state_nxt = we_q ? RESP : RDWAIT;
                else if (timeout)
                    state_nxt = RESP;
            end
            RDWAIT: state_nxt = RESP;
            RESP:   if (resp_ready_i) state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            we_q    <= 1'b0;
            src_q   <= '0;
            bsel_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                we_q    <= req_we_i;
                src_q   <= req_src_i;
                bsel_q  <= req_bsel_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
            end
            if ((done && we_q) || timeout)
                rdata_q <= '0;
            else if (state == RDWAIT)
                rdata_q <= reg_rdata_i;
        end
    end

    always_comb begin
        reg_en_o    = '0;
        reg_wben_o  = '0;
        reg_addr_o  = '0;
        reg_wdata_o = '0;
        if (state == ISSUE) begin
            reg_en_o    = {src_q[1], src_q[0], 1'b1};
            reg_addr_o  = addr_q;
            reg_wdata_o = wdata_q;
            for (int i = 0; i < TCU_REG_BSEL_SIZE; i++)
                reg_wben_o[i*8 +: 8] = {8{bsel_q[i] & we_q}};
        end
    end

    assign resp_valid_o = (state == RESP);
    assign resp_rdata_o = rdata_q;

endmodule

// File: tb/tb_tcu_reg_bridge.sv
// Directed testbench for tcu_reg_bridge: write, read, stall/backpressure,
// reset mid-read and (with TCU_REG_BRIDGE_TIMEOUT_EN) stall timeout.
module tb_tcu_reg_bridge;

`ifdef TCU_REG_BRIDGE_TIMEOUT_EN
    localparam int TMO     = 4;
    localparam int STALL_N = 3;
`else
    localparam int TMO     = 255;
    localparam int STALL_N = 5;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_src;
    logic [7:0]  req_bsel;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [2:0]  reg_en;
    logic [63:0] reg_wben;
    logic [31:0] reg_addr;
    logic [63:0] reg_wdata;
    logic [63:0] reg_rdata;
    logic        reg_stall;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tcu_reg_bridge #(
        .TCU_REG_DATA_SIZE(64),
        .TCU_REG_ADDR_SIZE(32),
        .TCU_REG_BSEL_SIZE(8),
        .TIMEOUT_CYCLES   (TMO)
    ) dut (
        .clk_i       (clk),
        .reset_n_i   (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_src_i   (req_src),
        .req_bsel_i  (req_bsel),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .resp_valid_o(resp_valid),
        .resp_ready_i(resp_ready),
        .resp_rdata_o(resp_rdata),
        .resp_err_o  (resp_err),
        .reg_en_o    (reg_en),
        .reg_wben_o  (reg_wben),
        .reg_addr_o  (reg_addr),
        .reg_wdata_o (reg_wdata),
        .reg_rdata_i (reg_rdata),
        .reg_stall_i (reg_stall)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the first negedge after acceptance.
    task automatic send(input logic we, input logic [1:0] src,
                        input logic [7:0] bsel, input logic [31:0] addr,
                        input logic [63:0] wdata);
        req_valid = 1'b1;
        req_we    = we;
        req_src   = src;
        req_bsel  = bsel;
        req_addr  = addr;
        req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_src    = 2'b00;
        req_bsel   = 8'h00;
        req_addr   = 32'h0;
        req_wdata  = 64'h0;
        resp_ready = 1'b1;
        reg_rdata  = 64'h0;
        reg_stall  = 1'b0;

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_rvalid", resp_valid, 0);
        chk("rst_en", reg_en, 0);
        chk("rst_wben", reg_wben, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_err", resp_err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", req_ready, 1);

        // write path: ISSUE at +1, response at +2
        send(1'b1, 2'b10, 8'h0F, 32'h10, 64'h1122334455667788);
        chk("wr_en", reg_en, 3'b101);
        chk("wr_wben", reg_wben, 64'h00000000FFFFFFFF);
        chk("wr_addr", reg_addr, 32'h10);
        chk("wr_wdata", reg_wdata, 64'h1122334455667788);
        chk("wr_ready1", req_ready, 0);
        chk("wr_rvalid1", resp_valid, 0);
        @(negedge clk);
        chk("wr_rvalid2", resp_valid, 1);
        chk("wr_err", resp_err, 0);
        chk("wr_rdata", resp_rdata, 0);
        chk("wr_en_resp", reg_en, 0);
        chk("wr_ready_resp", req_ready, 0);
        @(negedge clk);
        chk("wr_idle_ready", req_ready, 1);
        chk("wr_idle_rvalid", resp_valid, 0);

        // read path: data sampled only in RDWAIT, response at +3
        reg_rdata = 64'h5555555555555555;
        send(1'b0, 2'b01, 8'hFF, 32'h20, 64'h0123456789ABCDEF);
        chk("rd_en", reg_en, 3'b011);
        chk("rd_wben", reg_wben, 0);
        chk("rd_addr", reg_addr, 32'h20);
        @(negedge clk);
        reg_rdata = 64'hDEADBEEF00C0FFEE;
        chk("rd_wait_rvalid", resp_valid, 0);
        chk("rd_wait_en", reg_en, 0);
        @(negedge clk);
        reg_rdata = 64'hAAAAAAAAAAAAAAAA;
        chk("rd_rvalid", resp_valid, 1);
        chk("rd_rdata", resp_rdata, 64'hDEADBEEF00C0FFEE);
        chk("rd_err", resp_err, 0);
        @(negedge clk);
        chk("rd_idle_ready", req_ready, 1);

        // stall then response backpressure, src=11 forwarded as-is
        reg_stall = 1'b1;
        send(1'b1, 2'b11, 8'h81, 32'h30, 64'hCAFEF00DBAADC0DE);
        for (int k = 0; k < STALL_N; k++) begin
            chk("st_en", reg_en, 3'b111);
            chk("st_wben", reg_wben, 64'hFF000000000000FF);
            chk("st_addr", reg_addr, 32'h30);
            chk("st_wdata", reg_wdata, 64'hCAFEF00DBAADC0DE);
            chk("st_ready", req_ready, 0);
            @(negedge clk);
        end
        chk("st_last_en", reg_en, 3'b111);
        reg_stall  = 1'b0;
        resp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_rvalid", resp_valid, 1);
            chk("bp_rdata", resp_rdata, 0);
            chk("bp_err", resp_err, 0);
            chk("bp_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_done_rvalid", resp_valid, 0);
        chk("bp_done_ready", req_ready, 1);

        // reset during RDWAIT drops the read
        reg_rdata = 64'h123456789ABCDEF0;
        send(1'b0, 2'b10, 8'h01, 32'h40, 64'h0);
        chk("mr_en", reg_en, 3'b101);
        @(negedge clk);
        chk("mr_wait_en", reg_en, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mr_rvalid", resp_valid, 0);
        chk("mr_ready", req_ready, 0);
        chk("mr_en0", reg_en, 0);
        chk("mr_addr", reg_addr, 0);
        chk("mr_rdata", resp_rdata, 0);
        chk("mr_err", resp_err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_after_ready", req_ready, 1);
        for (int k = 0; k < 3; k++) begin
            chk("mr_no_resp", resp_valid, 0);
            @(negedge clk);
        end

`ifdef TCU_REG_BRIDGE_TIMEOUT_EN
        // permanent stall aborts after TMO stalled cycles
        reg_stall = 1'b1;
        send(1'b0, 2'b01, 8'hFF, 32'h50, 64'h0);
        for (int k = 0; k < TMO; k++) begin
            chk("to_en", reg_en, 3'b011);
            @(negedge clk);
        end
        chk("to_en_off", reg_en, 0);
        chk("to_rvalid", resp_valid, 1);
        chk("to_err", resp_err, 1);
        chk("to_rdata", resp_rdata, 0);
        reg_stall = 1'b0;
        @(negedge clk);
        chk("to_idle", req_ready, 1);
        chk("to_err_idle_rvalid", resp_valid, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
